ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: the opposite direction of the existing keyboard receive path. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset), using the PS/2 request-to-send sequence, and reports the device ACK. It drives the open-drain PS2_CLK/PS2_DAT pins through active-high pull-low enables that the top level converts to `1'b0 : 1'bz`. Its `busy` output gates the receiver so that the receiver ignores transmit clocks.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_line_sync.sv | 41 ++++
 rtl/ps2_host_tx.sv | 173 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 definitions for the host transmit and keyboard receive paths.
//   state_e      - host transmit FSM states
//   FRAME_BITS   - bits in one PS/2 frame (start, 8 data, parity, stop)
//   CMD_* / RSP_ - common keyboard command and response bytes
//   odd_parity() - parity bit that makes the 9-bit {parity, data} odd
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_e;

    localparam int unsigned FRAME_BITS = 11;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchronizer for the raw PS/2 clock and data pins plus
// a one-cycle strobe on each synchronized clock falling edge.
//   clk_i      in  system clock
//   rst_ni     in  synchronous active-low reset
//   ps2_clk_i  in  raw PS2_CLK pin level
//   ps2_dat_i  in  raw PS2_DAT pin level
//   clk_s_o    out synchronized clock level
//   dat_s_o    out synchronized data level
//   fall_o     out high for one cycle after a synchronized clock falling edge
module ps2_line_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic clk_s_o,
    output logic dat_s_o,
    output logic fall_o
);

    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       clk_prev_q;

    // Reset to the idle (high) line level so leaving reset never fakes an edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign clk_s_o = clk_sync_q[1];
    assign dat_s_o = dat_sync_q[1];
    assign fall_o  = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Sends one command byte using the
// request-to-send sequence and reports the device ACK/NACK.
// Optional feature macro: PS2_TX_TIMEOUT_EN enables the frame watchdog.
//   clk         in  system clock
//   rst_n       in  synchronous active-low reset
//   tx_data     in  command byte, captured on accept
//   tx_valid    in  request to send; accepted when tx_ready is high
//   tx_ready    out high only while idle
//   tx_done     out one-cycle pulse: byte ACKed and line idle
//   tx_error    out one-cycle pulse: NACK (or watchdog timeout)
//   busy        out high whenever not idle; gates the receiver
//   ps2_clk_in  in  raw PS2_CLK pin level
//   ps2_dat_in  in  raw PS2_DAT pin level
//   ps2_clk_oe  out 1 = pull PS2_CLK low
//   ps2_dat_oe  out 1 = pull PS2_DAT low
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    // One cycle counter serves the inhibit window and, when enabled, the
    // watchdog; the two never run at the same time.
    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                                      INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_e           state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             par_q, par_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ok_q, ok_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic clk_s, dat_s, fall;

    ps2_line_sync u_sync (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .ps2_clk_i (ps2_clk_in),
        .ps2_dat_i (ps2_dat_in),
        .clk_s_o   (clk_s),
        .dat_s_o   (dat_s),
        .fall_o    (fall)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
            cnt_q     <= '0;
            ok_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_q     <= par_d;
            bit_cnt_q <= bit_cnt_d;
            cnt_q     <= cnt_d;
            ok_q      <= ok_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        par_d      = par_q;
        bit_cnt_d  = bit_cnt_q;
        cnt_d      = '0;
        ok_d       = ok_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        ps2_clk_oe = 1'b0;
        ps2_dat_oe = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    data_d    = tx_data;
                    par_d     = odd_parity(tx_data);
                    bit_cnt_d = '0;
                    ok_d      = 1'b0;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                ps2_clk_oe = 1'b1;
                ps2_dat_oe = 1'b1;
                state_d    = SHIFT;
            end
            SHIFT: begin
                // bit_cnt counts device clock falls seen: 0 = start bit still
                // on the line, 1..8 = data LSB first, 9 = parity.
                if (bit_cnt_q == 4'd0) begin
                    ps2_dat_oe = 1'b1;
                end else if (bit_cnt_q <= 4'd8) begin
                    ps2_dat_oe = ~data_q[3'(bit_cnt_q - 4'd1)];
                end else begin
                    ps2_dat_oe = ~par_q;
                end
                if (fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(FRAME_BITS - 2)) begin
                        state_d = ACK;
                    end
                end
            end
            ACK: begin
                if (fall) begin
                    ok_d    = ~dat_s;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_s && dat_s) begin
                    done_d  = ok_q;
                    err_d   = ~ok_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        // Timeout overrides a same-cycle completion so done/error stay exclusive.
        if (state_q inside {SHIFT, ACK, WAIT_IDLE}) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                done_d  = 1'b0;
                err_d   = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end else if (state_d != IDLE) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`endif
    end

    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign tx_done  = done_q;
    assign tx_error = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: self-checking bench for ps2_host_tx with an open-drain PS/2
// device model that clocks frames, records the host line bits and ACKs/NACKs.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int unsigned INH = 5000;
    localparam int unsigned TMO = 2000;
    localparam int unsigned H   = 12;   // device clock half period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, busy;
    logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    // Wired-AND open-drain bus with pull-ups.
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .busy       (busy),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    always #10 clk = ~clk;

    int done_cnt = 0;
    int err_cnt  = 0;
    always @(posedge clk) begin
        if (tx_done)  done_cnt <= done_cnt + 1;
        if (tx_error) err_cnt  <= err_cnt + 1;
    end

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        int n = 0;
        while (!tx_ready && n < 1000) begin
            tick(1);
            n++;
        end
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic dev_pulse(output logic smp);
        dev_clk_low = 1'b1;
        tick(H);
        dev_clk_low = 1'b0;
        tick(H / 2);
        smp = ps2_dat_in;
        tick(H / 2);
    endtask

    // Request-to-send is visible as clock released with data held low.
    task automatic wait_req(output bit ok);
        int n = 0;
        while (!(ps2_clk_in && !ps2_dat_in) && n < int'(INH + 1000)) begin
            tick(1);
            n++;
        end
        ok = (n < int'(INH + 1000));
        if (!ok) check("request_seen", 32'd0, 32'd1);
    endtask

    task automatic dev_frame(input bit ack, input int poke, output logic [10:0] bits);
        bit   ok;
        logic b;
        bits = '1;
        wait_req(ok);
        if (!ok) return;
        tick(4);
        bits[0] = ps2_dat_in;
        for (int i = 1; i <= 10; i++) begin
            dev_pulse(b);
            bits[i] = b;
            if (i == poke) begin
                check("ready_low_in_shift", 32'(tx_ready), 32'd0);
                tx_data  = 8'h12;
                tx_valid = 1'b1;
                tick(1);
                tx_valid = 1'b0;
            end
        end
        if (ack) dev_dat_low = 1'b1;
        tick(4);
        dev_pulse(b);
        dev_dat_low = 1'b0;
    endtask

    typedef struct {
        string      name;
        logic [7:0] data;
        bit         ack;
        int         poke;
        logic [10:0] line;   // {stop, parity, d7..d0, start}
        int         done;
        int         err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [10:0] bits;
        bit          ok;
        logic        b;
        int          n, d0, e0;

        vecs[0] = '{"ff_after_reset", CMD_RESET,    1'b1, 0, 11'b1_1_1111_1111_0, 1, 0};
        vecs[1] = '{"ed_ack",         CMD_SET_LEDS, 1'b1, 0, 11'b1_1_1110_1101_0, 1, 0};
        vecs[2] = '{"ed_busy_reject", CMD_SET_LEDS, 1'b1, 3, 11'b1_1_1110_1101_0, 1, 0};
        vecs[3] = '{"zero_nack",      8'h00,        1'b0, 0, 11'b1_1_0000_0000_0, 0, 1};
        vecs[4] = '{"fa_ack",         RSP_ACK,      1'b1, 0, 11'b1_1_1111_1010_0, 1, 0};

        // Reset state
        tick(3);
        check("reset_outputs",
              32'({tx_ready, busy, ps2_clk_oe, ps2_dat_oe, tx_done, tx_error}), 32'b100000);
        rst_n = 1'b1;
        tick(2);

        // Inhibit window with 0xF4
        d0 = done_cnt; e0 = err_cnt;
        send(CMD_ENABLE);
        check("accept_clk_oe", 32'(ps2_clk_oe), 32'd1);
        check("accept_busy",   32'(busy),       32'd1);
        check("accept_dat_oe", 32'(ps2_dat_oe), 32'd0);
        n = 0;
        while (!ps2_dat_oe && n < int'(INH + 100)) begin
            if (ps2_clk_oe) n++;
            tick(1);
        end
        check("inhibit_len",  32'(n),          32'(INH));
        check("req_clk_oe",   32'(ps2_clk_oe), 32'd1);
        tick(1);
        check("shift_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("shift_dat_oe", 32'(ps2_dat_oe), 32'd1);
        dev_frame(1'b1, 0, bits);
        tick(8);
        check("f4_line",  32'(bits),              32'(11'b1_0_1111_0100_0));
        check("f4_done",  32'(done_cnt - d0),     32'd1);
        check("f4_error", 32'(err_cnt - e0),      32'd0);

        // Reset after fall 4 of 0xFF
        send(CMD_RESET);
        wait_req(ok);
        tick(4);
        for (int i = 0; i < 4; i++) dev_pulse(b);
        check("pre_reset_busy", 32'(busy), 32'd1);
        d0 = done_cnt; e0 = err_cnt;
        rst_n = 1'b0;
        tick(1);
        check("midreset_oe",    32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        check("midreset_busy",  32'(busy),     32'd0);
        check("midreset_ready", 32'(tx_ready), 32'd1);
        rst_n = 1'b1;
        tick(10);
        check("midreset_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            d0 = done_cnt; e0 = err_cnt;
            send(vecs[v].data);
            dev_frame(vecs[v].ack, vecs[v].poke, bits);
            tick(8);
            check({vecs[v].name, "_line"},  32'(bits),          32'(vecs[v].line));
            check({vecs[v].name, "_done"},  32'(done_cnt - d0), 32'(vecs[v].done));
            check({vecs[v].name, "_error"}, 32'(err_cnt - e0),  32'(vecs[v].err));
            check({vecs[v].name, "_idle"},  32'({tx_ready, busy}), 32'b10);
        end

        // Silent device
        send(8'h55);
        n = 0;
        while (!(!ps2_clk_oe && ps2_dat_oe) && n < int'(INH + 100)) begin
            tick(1);
            n++;
        end
        d0 = done_cnt; e0 = err_cnt;
`ifdef PS2_TX_TIMEOUT_EN
        n = 0;
        while (!tx_error && n < int'(TMO + 100)) begin
            tick(1);
            n++;
        end
        check("timeout_len",   32'(n), 32'(TMO));
        check("timeout_oe",    32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        check("timeout_ready", 32'(tx_ready), 32'd1);
        tick(4);
        check("timeout_one_error", 32'(err_cnt - e0), 32'd1);
        check("timeout_no_done",   32'(done_cnt - d0), 32'd0);
`else
        tick(int'(TMO) + 1000);
        check("nowd_still_busy", 32'({busy, tx_ready}), 32'b10);
        check("nowd_no_pulse",   32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("nowd_reset_idle", 32'({busy, tx_ready}), 32'b01);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", nerr);
        $fatal(1);
    end

endmodule
